// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO with youngest-entry coalescing, load forwarding and fence drain
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic [DW/8-1:0]          st_wmask,
  output logic                     cache_wr_valid,
  input  logic                     cache_wr_ready,
  output logic [AW-1:0]            cache_wr_addr,
  output logic [DW-1:0]            cache_wr_data,
  output logic [DW/8-1:0]          cache_wr_wmask,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_fwd_hit,
  output logic [DW-1:0]            ld_fwd_data,
  output logic [DW/8-1:0]          ld_fwd_mask,
  input  logic                     fence_req,
  output logic                     fence_done,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int MW  = DW / 8;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WAW = AW - 2;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C  = CW'(2);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [WAW-1:0] waddr_q [DEPTH];
  logic [DW-1:0]  data_q  [DEPTH];
  logic [MW-1:0]  mask_q  [DEPTH];
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     state_q, state_d;

  logic [WAW-1:0] st_waddr, ld_waddr;
  logic [PW-1:0]  youngest;
  logic           st_live, coal, enq, deq;
  logic           unused_addr_bits;

  assign st_waddr = st_addr[AW-1:2];
  assign ld_waddr = ld_addr[AW-1:2];
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};
  assign youngest = tail_q - 1'b1;

  assign st_ready = (state_q == S_RUN) && (count_q < FULL_C);
  // Zero-mask stores are handshaken but leave no trace.
  assign st_live  = st_valid && st_ready && (st_wmask != '0);
  // count>=2 keeps the head (being presented to the arbiter) out of merges.
  assign coal     = st_live && (count_q >= TWO_C) && (waddr_q[youngest] == st_waddr);
  assign enq      = st_live && !coal;
  assign deq      = cache_wr_valid && cache_wr_ready;

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (fence_req) state_d = S_WAIT;
      S_WAIT:  if (count_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_RUN;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        mask_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      if (deq) head_q <= head_q + 1'b1;
      if (enq) begin
        waddr_q[tail_q] <= st_waddr;
        data_q[tail_q]  <= st_data;
        mask_q[tail_q]  <= st_wmask;
        tail_q          <= tail_q + 1'b1;
      end
      if (coal) begin
        mask_q[youngest] <= mask_q[youngest] | st_wmask;
        for (int b = 0; b < MW; b++) begin
          if (st_wmask[b]) data_q[youngest][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  // Walk oldest to youngest so later entries overwrite earlier lanes.
  logic [PW-1:0] fwd_idx;
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = '0;
    ld_fwd_mask = '0;
    fwd_idx     = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (waddr_q[fwd_idx] == ld_waddr)) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_mask = ld_fwd_mask | mask_q[fwd_idx];
        for (int b = 0; b < MW; b++) begin
          if (mask_q[fwd_idx][b]) ld_fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
        end
      end
    end
  end

  assign cache_wr_valid = (count_q != '0);
  assign cache_wr_addr  = {waddr_q[head_q], 2'b00};
  assign cache_wr_data  = data_q[head_q];
  assign cache_wr_wmask = mask_q[head_q];
  assign fence_done     = (state_q == S_DONE);
  assign sb_empty       = (count_q == '0);
  assign sb_count       = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed scoreboard bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_wmask = '0;
  logic        cache_wr_valid;
  logic        cache_wr_ready = 1'b0;
  logic [31:0] cache_wr_addr;
  logic [31:0] cache_wr_data;
  logic [3:0]  cache_wr_wmask;
  logic [31:0] ld_addr = '0;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_mask;
  logic        fence_req = 1'b0;
  logic        fence_done;
  logic        sb_empty;
  logic [2:0]  sb_count;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_wmask(st_wmask),
    .cache_wr_valid(cache_wr_valid), .cache_wr_ready(cache_wr_ready),
    .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
    .cache_wr_wmask(cache_wr_wmask),
    .ld_addr(ld_addr), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
    .ld_fwd_mask(ld_fwd_mask),
    .fence_req(fence_req), .fence_done(fence_done),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_t w;
    w.addr = a; w.data = d; w.mask = m;
    exp_q.push_back(w);
  endtask

  // Monitor: every accepted cache write must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && cache_wr_valid && cache_wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", cache_wr_addr, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", cache_wr_addr, w.addr);
          chk("wr_data", cache_wr_data, w.data);
          chk("wr_mask", {28'd0, cache_wr_wmask}, {28'd0, w.mask});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1; st_addr = a; st_data = d; st_wmask = m;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int n = 0;
    drive_store(a, d, m);
    while (!st_ready && n < 50) begin
      step();
      n++;
    end
    chk("st_ready_wait", {31'd0, st_ready}, 32'd1);
    step();
    st_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_wr_valid", {31'd0, cache_wr_valid}, 32'd0);
    chk("rst_fence_done", {31'd0, fence_done}, 32'd0);
    chk("rst_fwd_hit", {31'd0, ld_fwd_hit}, 32'd0);
    chk("rst_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_count", {29'd0, sb_count}, 32'd0);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    rst = 1'b1;
    step();

    // 1: fill, then drain one per cycle in order
    for (int i = 0; i < 4; i++) store(32'h100 + 4*i, 32'h100 + 4*i, 4'hF);
    chk("t1_count", {29'd0, sb_count}, 32'd4);
    chk("t1_st_ready", {31'd0, st_ready}, 32'd0);
    for (int i = 0; i < 4; i++) expect_wr(32'h100 + 4*i, 32'h100 + 4*i, 4'hF);
    cache_wr_ready = 1'b1;
    step(); step(); step(); step();
    chk("t1_empty", {31'd0, sb_empty}, 32'd1);
    cache_wr_ready = 1'b0;

    // 2: coalesce into youngest, zero mask ignored
    store(32'h200, 32'h1122_3344, 4'hF);
    store(32'h300, 32'h5566_7788, 4'hF);
    store(32'h300, 32'hAABB_CCDD, 4'h3);
    store(32'h304, 32'hDEAD_BEEF, 4'h0);
    chk("t2_count", {29'd0, sb_count}, 32'd2);
    ld_addr = 32'h301;
    #1;
    chk("t2_fwd_data", ld_fwd_data, 32'h5566_CCDD);
    expect_wr(32'h200, 32'h1122_3344, 4'hF);
    expect_wr(32'h300, 32'h5566_CCDD, 4'hF);
    cache_wr_ready = 1'b1;
    step(); step();
    chk("t2_empty", {31'd0, sb_empty}, 32'd1);
    cache_wr_ready = 1'b0;

    // 3: forwarding merge, no merge on head, no bypass
    ld_addr = 32'h42;
    drive_store(32'h40, 32'h0000_00AA, 4'h1);
    #1;
    chk("t3_no_bypass", {31'd0, ld_fwd_hit}, 32'd0);
    step();
    st_valid = 1'b0;
    store(32'h40, 32'h0000_BB00, 4'h2);
    chk("t3_count", {29'd0, sb_count}, 32'd2);
    chk("t3_hit", {31'd0, ld_fwd_hit}, 32'd1);
    chk("t3_mask", {28'd0, ld_fwd_mask}, 32'd3);
    chk("t3_data", ld_fwd_data, 32'h0000_BBAA);
    store(32'h80, 32'h1234_5678, 4'hF);
    ld_addr = 32'h44;
    #1;
    chk("t3_miss_hit", {31'd0, ld_fwd_hit}, 32'd0);
    chk("t3_miss_data", ld_fwd_data, 32'd0);
    expect_wr(32'h40, 32'h0000_00AA, 4'h1);
    expect_wr(32'h40, 32'h0000_BB00, 4'h2);
    expect_wr(32'h80, 32'h1234_5678, 4'hF);
    cache_wr_ready = 1'b1;
    step(); step(); step();
    cache_wr_ready = 1'b0;
    store(32'h50, 32'h0000_00AA, 4'h1);
    store(32'h50, 32'h0000_BBCC, 4'h3);
    ld_addr = 32'h50;
    #1;
    chk("t3_youngest_data", ld_fwd_data, 32'h0000_BBCC);
    chk("t3_youngest_mask", {28'd0, ld_fwd_mask}, 32'd3);
    expect_wr(32'h50, 32'h0000_00AA, 4'h1);
    expect_wr(32'h50, 32'h0000_BBCC, 4'h3);
    cache_wr_ready = 1'b1;
    step(); step();
    chk("t3_empty", {31'd0, sb_empty}, 32'd1);
    cache_wr_ready = 1'b0;

    // 4: full with simultaneous dequeue does not accept
    for (int i = 0; i < 4; i++) store(32'h400 + 4*i, 32'hA000 + i, 4'hF);
    for (int i = 0; i < 4; i++) expect_wr(32'h400 + 4*i, 32'hA000 + i, 4'hF);
    drive_store(32'h500, 32'h5555_5555, 4'hF);
    cache_wr_ready = 1'b1;
    #1;
    chk("t4_full_ready", {31'd0, st_ready}, 32'd0);
    step();
    st_valid = 1'b0;
    chk("t4_count", {29'd0, sb_count}, 32'd3);
    chk("t4_ready_next", {31'd0, st_ready}, 32'd1);
    step(); step(); step();
    chk("t4_empty", {31'd0, sb_empty}, 32'd1);
    cache_wr_ready = 1'b0;

    // 5: fence with a stalled buffer, then on an empty one
    for (int i = 0; i < 3; i++) store(32'h600 + 4*i, 32'hB000 + i, 4'hF);
    for (int i = 0; i < 3; i++) expect_wr(32'h600 + 4*i, 32'hB000 + i, 4'hF);
    fence_req = 1'b1;
    step();
    fence_req = 1'b0;
    chk("t5_wait_st_ready", {31'd0, st_ready}, 32'd0);
    chk("t5_wait_done", {31'd0, fence_done}, 32'd0);
    cache_wr_ready = 1'b1;
    step(); step(); step();
    chk("t5_count0", {29'd0, sb_count}, 32'd0);
    chk("t5_not_done_yet", {31'd0, fence_done}, 32'd0);
    step();
    chk("t5_done", {31'd0, fence_done}, 32'd1);
    chk("t5_done_st_ready", {31'd0, st_ready}, 32'd0);
    step();
    chk("t5_done_pulse", {31'd0, fence_done}, 32'd0);
    chk("t5_run_st_ready", {31'd0, st_ready}, 32'd1);
    fence_req = 1'b1;
    step();
    fence_req = 1'b0;
    chk("t5_empty_c1", {31'd0, fence_done}, 32'd0);
    step();
    chk("t5_empty_c2", {31'd0, fence_done}, 32'd1);
    step();
    chk("t5_empty_c3", {31'd0, fence_done}, 32'd0);
    cache_wr_ready = 1'b0;

    // 6: async reset mid-stall discards entries
    store(32'h700, 32'hC000, 4'hF);
    store(32'h704, 32'hC001, 4'hF);
    chk("t6_count", {29'd0, sb_count}, 32'd2);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, cache_wr_valid}, 32'd0);
    chk("t6_rst_count", {29'd0, sb_count}, 32'd0);
    cache_wr_ready = 1'b1;
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t6_post_valid", {31'd0, cache_wr_valid}, 32'd0);
    chk("t6_post_empty", {31'd0, sb_empty}, 32'd1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
